// File: rtl/fdce_fdpe.sv
// Bank of D flip-flops with per-bit clock enable and a shared async active-low reset.
// Each bit clears (FDCE) or presets (FDPE) on reset according to its RESET_VAL bit.
module fdce_fdpe #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Power-up value is carried as the register's initial value, matching the primitive's INIT.
    logic [WIDTH-1:0] q_r = INIT;
    logic [WIDTH-1:0] next_s;

    // Per-bit enable mux: enabled bits take d, the others recirculate.
    always_comb begin
        next_s = (ce & d) | (~ce & q_r);
    end

    // Flop bank; an unknown clr_n poisons q instead of being read as deasserted.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_r <= RESET_VAL;
        end else if (clr_n) begin
            q_r <= next_s;
        end else begin
            q_r <= {WIDTH{1'bx}};
        end
    end

    assign q = q_r;

endmodule

// File: tb/tb_fdce_fdpe.sv
// Scoreboard bench for fdce_fdpe: four instances cover INIT, mixed presets,
// clock enable, reset dominance, simultaneous edges and WIDTH=1 FDCE/FDPE.
module tb_fdce_fdpe;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic [7:0] d = 8'h00;
    logic       clr_a = 1'b1, clr_b = 1'b1, clr_c = 1'b1, clr_d = 1'b1;
    logic [7:0] ce_a = 8'h00, ce_b = 8'h00;
    logic       ce_c = 1'b0, ce_d = 1'b0;
    logic [7:0] q_a, q_b;
    logic       q_c, q_d;

    int tests_run = 0;
    int fails = 0;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    event chk_ev;

    fdce_fdpe #(.WIDTH(8), .INIT(8'hA5), .RESET_VAL(8'hF0)) dut_a (
        .clk(clk), .clr_n(clr_a), .ce(ce_a), .d(d), .q(q_a));
    fdce_fdpe #(.WIDTH(8), .INIT(8'h00), .RESET_VAL(8'h81)) dut_b (
        .clk(clk), .clr_n(clr_b), .ce(ce_b), .d(d), .q(q_b));
    fdce_fdpe #(.WIDTH(1), .INIT(1'b0), .RESET_VAL(1'b0)) dut_c (
        .clk(clk), .clr_n(clr_c), .ce(ce_c), .d(d[0]), .q(q_c));
    fdce_fdpe #(.WIDTH(1), .INIT(1'b0), .RESET_VAL(1'b1)) dut_d (
        .clk(clk), .clr_n(clr_d), .ce(ce_d), .d(d[0]), .q(q_d));

    always #5 if (clk_run) clk = ~clk;

    task automatic expect_q(input string name, input int sel, input logic [7:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
        ->chk_ev;
    endtask

    task automatic edge_then(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick(input int sel);
        case (sel)
            0: return q_a;
            1: return q_b;
            2: return {7'b0000000, q_c};
            default: return {7'b0000000, q_d};
        endcase
    endfunction

    // Monitor: drains the scoreboard whenever a sample point is announced.
    initial begin
        forever begin
            @chk_ev;
            while (sb.size() > 0) begin
                exp_t e;
                logic [7:0] act;
                e = sb.pop_front();
                act = pick(e.sel);
                tests_run++;
                if (act !== e.exp) begin
                    fails++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $fatal(1);
    end

    initial begin
        // Power-up, no edges yet
        #1;
        expect_q("powerup_a", 0, 8'hA5);
        expect_q("powerup_b", 1, 8'h00);
        expect_q("powerup_c", 2, 8'h00);
        expect_q("powerup_d", 3, 8'h00);

        // First enabled edge on A; B/C/D disabled
        ce_a = 8'hFF;
        d    = 8'h3C;
        clk_run = 1'b1;
        edge_then(1);
        expect_q("first_load_a", 0, 8'h3C);
        expect_q("ce_off_b", 1, 8'h00);

        // Async reset with clock stopped
        @(negedge clk);
        clk_run = 1'b0;
        d = 8'h55;
        #2;
        clr_a = 1'b0;
        #1;
        expect_q("async_reset_a", 0, 8'hF0);

        // Reset dominance over enabled edges
        clk_run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_then(1);
            expect_q("reset_hold_a", 0, 8'hF0);
        end
        @(negedge clk);
        clr_a = 1'b1;
        #1;
        expect_q("release_hold_a", 0, 8'hF0);
        edge_then(1);
        expect_q("reload_a", 0, 8'h55);

        // Per-bit clock enable on B from 0x00
        ce_b = 8'h0F;
        d    = 8'hFF;
        edge_then(1);
        expect_q("ce_lower_b", 1, 8'h0F);
        ce_b = 8'h00;
        d    = 8'h00;
        for (int i = 0; i < 4; i++) begin
            edge_then(1);
            expect_q("ce_hold_b", 1, 8'h0F);
        end

        // Reset falls in the same timestep as a clock rise
        ce_b = 8'hFF;
        d    = 8'hAA;
        @(posedge clk);
        clr_b = 1'b0;
        #1;
        expect_q("simul_reset_b", 1, 8'h81);
        edge_then(1);
        expect_q("simul_hold_b", 1, 8'h81);
        @(negedge clk);
        clr_b = 1'b1;
        edge_then(1);
        expect_q("simul_reload_b", 1, 8'hAA);

        // WIDTH=1: put C at 1 so its clear is visible, D stays at 0
        ce_b = 8'h00;
        ce_c = 1'b1;
        ce_d = 1'b0;
        d    = 8'hFF;
        edge_then(1);
        expect_q("w1_load_c", 2, 8'h01);
        expect_q("w1_hold_d", 3, 8'h00);
        @(negedge clk);
        clr_c = 1'b0;
        clr_d = 1'b0;
        #1;
        expect_q("w1_fdce_c", 2, 8'h00);
        expect_q("w1_fdpe_d", 3, 8'h01);
        edge_then(1);
        expect_q("w1_reset_hold_c", 2, 8'h00);
        expect_q("w1_reset_hold_d", 3, 8'h01);
        @(negedge clk);
        clr_c = 1'b1;
        clr_d = 1'b1;
        #1;
        expect_q("w1_release_d", 3, 8'h01);
        edge_then(1);
        expect_q("w1_reload_c", 2, 8'h01);
        ce_c = 1'b0;
        ce_d = 1'b1;
        d    = 8'h00;
        edge_then(1);
        expect_q("w1_reload_d", 3, 8'h00);
        expect_q("w1_ce_off_c", 2, 8'h01);

        #2;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
